// File: rtl/traffic_light_ped.sv
// Two-way traffic light controller with all-red clearance and a latched
// pedestrian request served by an all-red walk phase. Phases advance on tick.
module traffic_light_ped #(
    parameter int unsigned GREEN_TICKS  = 5,
    parameter int unsigned YELLOW_TICKS = 2,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned WALK_TICKS   = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic ped_req,
    output logic ns_g,
    output logic ns_y,
    output logic ns_r,
    output logic ew_g,
    output logic ew_y,
    output logic ew_r,
    output logic walk,
    output logic ped_wait
);

    localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(WALK_TICKS - 1);

    // Lamp vector order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
    localparam logic [6:0] LAMP_NS_G = 7'b100_001_0;
    localparam logic [6:0] LAMP_NS_Y = 7'b010_001_0;
    localparam logic [6:0] LAMP_AR   = 7'b001_001_0;
    localparam logic [6:0] LAMP_EW_G = 7'b001_100_0;
    localparam logic [6:0] LAMP_EW_Y = 7'b001_010_0;
    localparam logic [6:0] LAMP_WALK = 7'b001_001_1;

    typedef enum logic [2:0] {
        S_NS_G = 3'd0,
        S_NS_Y = 3'd1,
        S_AR   = 3'd2,
        S_EW_G = 3'd3,
        S_EW_Y = 3'd4,
        S_WALK = 3'd5
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             dir_ew_q, dir_ew_nxt;   // 1: next green after all-red is EW
    logic             pend_q, pend_nxt;
    logic [6:0]       lamp_q, lamp_nxt;
    logic [CNT_W-1:0] last_cnt;
    logic             phase_done;
    logic             walk_entry;

    // State, counter, direction, pedestrian latch and lamp registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_NS_G;
            cnt_q    <= '0;
            dir_ew_q <= 1'b1;
            pend_q   <= 1'b0;
            lamp_q   <= LAMP_NS_G;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            dir_ew_q <= dir_ew_nxt;
            pend_q   <= pend_nxt;
            lamp_q   <= lamp_nxt;
        end
    end

    // Phase timing, transitions, request latch and next-lamp decode
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        dir_ew_nxt = dir_ew_q;
        lamp_nxt   = LAMP_AR;
        last_cnt   = G_LAST;

        case (state_q)
            S_NS_G, S_EW_G: last_cnt = G_LAST;
            S_NS_Y, S_EW_Y: last_cnt = Y_LAST;
            S_AR:           last_cnt = AR_LAST;
            S_WALK:         last_cnt = W_LAST;
            default:        last_cnt = G_LAST;
        endcase

        phase_done = tick && (cnt_q == last_cnt);

        if (tick) begin
            if (phase_done) begin
                cnt_nxt = '0;
                case (state_q)
                    S_NS_G: state_nxt = S_NS_Y;
                    S_NS_Y: begin
                        state_nxt  = S_AR;
                        dir_ew_nxt = 1'b1;
                    end
                    S_EW_G: state_nxt = S_EW_Y;
                    S_EW_Y: begin
                        state_nxt  = S_AR;
                        dir_ew_nxt = 1'b0;
                    end
                    S_AR: begin
                        if (pend_q)        state_nxt = S_WALK;
                        else if (dir_ew_q) state_nxt = S_EW_G;
                        else               state_nxt = S_NS_G;
                    end
                    S_WALK:  state_nxt = dir_ew_q ? S_EW_G : S_NS_G;
                    default: state_nxt = S_NS_G;
                endcase
            end else begin
                cnt_nxt = cnt_q + CNT_W'(1);
            end
        end

        // Requests during walk or on the walk-entry edge are absorbed by that walk
        walk_entry = (state_q == S_AR) && phase_done && pend_q;
        pend_nxt   = (pend_q | ped_req) & (state_q != S_WALK) & ~walk_entry;

        case (state_nxt)
            S_NS_G:  lamp_nxt = LAMP_NS_G;
            S_NS_Y:  lamp_nxt = LAMP_NS_Y;
            S_AR:    lamp_nxt = LAMP_AR;
            S_EW_G:  lamp_nxt = LAMP_EW_G;
            S_EW_Y:  lamp_nxt = LAMP_EW_Y;
            S_WALK:  lamp_nxt = LAMP_WALK;
            default: lamp_nxt = LAMP_AR;
        endcase
    end

    assign {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk} = lamp_q;
    assign ped_wait = pend_q;

endmodule

// File: tb/tb_traffic_light_ped.sv
// Scoreboard bench for traffic_light_ped: default instance plus a short-phase instance.
module tb_traffic_light_ped;

    // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_wait}
    localparam logic [7:0] L_NSG  = 8'b100_001_0_0;
    localparam logic [7:0] L_NSY  = 8'b010_001_0_0;
    localparam logic [7:0] L_AR   = 8'b001_001_0_0;
    localparam logic [7:0] L_EWG  = 8'b001_100_0_0;
    localparam logic [7:0] L_EWY  = 8'b001_010_0_0;
    localparam logic [7:0] L_WALK = 8'b001_001_1_0;
    localparam int NONE = 100000;

    logic clk, rst, tick, ped_req;
    logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_wait;
    logic rst2, tick2, ped_req2;
    logic ns_g2, ns_y2, ns_r2, ew_g2, ew_y2, ew_r2, walk2, ped_wait2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];
    logic [7:0] got, got2;

    assign got  = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_wait};
    assign got2 = {ns_g2, ns_y2, ns_r2, ew_g2, ew_y2, ew_r2, walk2, ped_wait2};

    traffic_light_ped dut (
        .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req),
        .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
        .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
        .walk(walk), .ped_wait(ped_wait)
    );

    traffic_light_ped #(
        .GREEN_TICKS(1), .YELLOW_TICKS(1), .ALLRED_TICKS(2), .WALK_TICKS(3), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rst(rst2), .tick(tick2), .ped_req(ped_req2),
        .ns_g(ns_g2), .ns_y(ns_y2), .ns_r(ns_r2),
        .ew_g(ew_g2), .ew_y(ew_y2), .ew_r(ew_r2),
        .walk(walk2), .ped_wait(ped_wait2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and, if checked, queue the outputs expected during it
    task automatic step(input logic r, input logic t, input logic p,
                        input logic chk, input logic [7:0] e);
        @(negedge clk);
        rst = r; tick = t; ped_req = p;
        if (chk) exp_q.push_back(e);
    endtask

    // One phase of dur ticks, a tick on the last clock of every per-clock period
    task automatic phase(input logic [7:0] lamp, input int dur, input int per,
                         input int req_lo, input int req_hi,
                         input logic pw0, input int pw_on);
        for (int i = 0; i < dur * per; i++) begin
            logic pw;
            pw = (i >= pw_on) ? 1'b1 : pw0;
            step(1'b0, (i % per) == per - 1, (i >= req_lo) && (i <= req_hi),
                 1'b1, lamp | {7'b0, pw});
        end
    endtask

    // Scoreboard monitor for the default instance
    always @(negedge clk) begin
        logic [7:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL lamps t=%0t got=%b exp=%b", $time, got, e);
            end
        end
    end

    // Scoreboard monitor for the short-phase instance
    always @(negedge clk) begin
        logic [7:0] e;
        #1;
        if (exp2_q.size() > 0) begin
            e = exp2_q.pop_front();
            n_tests++;
            if (got2 !== e) begin
                n_fail++;
                $display("FAIL lamps2 t=%0t got=%b exp=%b", $time, got2, e);
            end
        end
    end

    // Conflicting greens/yellows must never show on either instance
    always @(negedge clk) begin
        #1;
        if (rst === 1'b0) begin
            n_tests++;
            if ((ns_g | ns_y) & (ew_g | ew_y)) begin
                n_fail++;
                $display("FAIL safety t=%0t got=%b exp=no NS/EW overlap", $time, got);
            end
        end
        if (rst2 === 1'b0) begin
            n_tests++;
            if ((ns_g2 | ns_y2) & (ew_g2 | ew_y2)) begin
                n_fail++;
                $display("FAIL safety2 t=%0t got=%b exp=no NS/EW overlap", $time, got2);
            end
        end
    end

    // Short-phase instance: tick every clock, 8-clock repeating sequence
    initial begin
        logic [7:0] tbl [8];
        tbl[0] = L_NSG; tbl[1] = L_NSY; tbl[2] = L_AR;  tbl[3] = L_AR;
        tbl[4] = L_EWG; tbl[5] = L_EWY; tbl[6] = L_AR;  tbl[7] = L_AR;
        rst2 = 1'b1; tick2 = 1'b1; ped_req2 = 1'b0;
        @(negedge clk);
        @(negedge clk); exp2_q.push_back(L_NSG);
        @(negedge clk); exp2_q.push_back(L_NSG);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            rst2 = 1'b0;
            exp2_q.push_back(tbl[k % 8]);
        end
    end

    // Directed sequences on the default instance
    initial begin
        rst = 1'b1; tick = 1'b0; ped_req = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b0, L_NSG);
        step(1'b1, 1'b1, 1'b1, 1'b1, L_NSG);
        step(1'b1, 1'b0, 1'b0, 1'b1, L_NSG);

        // Nominal cycle, tick every 6 clocks, no pedestrian
        phase(L_NSG, 5, 6, NONE, -1, 1'b0, NONE);
        phase(L_NSY, 2, 6, NONE, -1, 1'b0, NONE);
        phase(L_AR,  1, 6, NONE, -1, 1'b0, NONE);
        phase(L_EWG, 5, 6, NONE, -1, 1'b0, NONE);
        phase(L_EWY, 2, 6, NONE, -1, 1'b0, NONE);
        phase(L_AR,  1, 6, NONE, -1, 1'b0, NONE);

        // Pulse in NS green tick 2: served by walk, then EW green
        phase(L_NSG,  5, 6, 7, 7, 1'b0, 8);
        phase(L_NSY,  2, 6, NONE, -1, 1'b1, NONE);
        phase(L_AR,   1, 6, NONE, -1, 1'b1, NONE);
        phase(L_WALK, 3, 6, NONE, -1, 1'b0, NONE);
        phase(L_EWG,  5, 6, NONE, -1, 1'b0, NONE);
        phase(L_EWY,  2, 6, NONE, -1, 1'b0, NONE);
        phase(L_AR,   1, 6, NONE, -1, 1'b0, NONE);

        // Request held through the walk and released at its end: no second walk
        phase(L_NSG,  5, 6, 3, NONE, 1'b0, 4);
        phase(L_NSY,  2, 6, 0, NONE, 1'b1, NONE);
        phase(L_AR,   1, 6, 0, NONE, 1'b1, NONE);
        phase(L_WALK, 3, 6, 0, NONE, 1'b0, NONE);
        phase(L_EWG,  5, 6, NONE, -1, 1'b0, NONE);
        phase(L_EWY,  2, 6, NONE, -1, 1'b0, NONE);
        phase(L_AR,   1, 6, NONE, -1, 1'b0, NONE);

        // Reset in walk tick 2 with a fresh request: full NS green follows
        phase(L_NSG, 5, 6, 0, 0, 1'b0, 1);
        phase(L_NSY, 2, 6, NONE, -1, 1'b1, NONE);
        phase(L_AR,  1, 6, NONE, -1, 1'b1, NONE);
        for (int i = 0; i < 9; i++) step(1'b0, i == 5, 1'b0, 1'b1, L_WALK);
        step(1'b1, 1'b1, 1'b1, 1'b1, L_WALK);
        phase(L_NSG, 5, 6, NONE, -1, 1'b0, NONE);
        phase(L_NSY, 2, 6, NONE, -1, 1'b0, NONE);
        phase(L_AR,  1, 6, NONE, -1, 1'b0, NONE);

        // Tick every clock: phases last DUR clocks, 16-clock cycle
        phase(L_EWG, 5, 1, NONE, -1, 1'b0, NONE);
        phase(L_EWY, 2, 1, NONE, -1, 1'b0, NONE);
        phase(L_AR,  1, 1, NONE, -1, 1'b0, NONE);
        phase(L_NSG, 5, 1, NONE, -1, 1'b0, NONE);
        phase(L_NSY, 2, 1, NONE, -1, 1'b0, NONE);
        phase(L_AR,  1, 1, NONE, -1, 1'b0, NONE);
        phase(L_EWG, 5, 1, NONE, -1, 1'b0, NONE);

        step(1'b0, 1'b0, 1'b0, 1'b0, L_NSG);
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0 || exp2_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d/%0d exp=0/0 pending entries",
                     exp_q.size(), exp2_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_ped.md
Name: traffic_light_ped

Overview:
- Parametrised two-way (NS/EW) traffic light controller with configurable phase durations counted in `tick` pulses.
- Adds what the fixed controller lacks: an all-red clearance interval between directions, and a latched pedestrian request served by an all-red walk phase.
- Sits downstream of the shared tick prescaler; its outputs drive the lamp drivers directly.

Parameters:
- GREEN_TICKS, 5, ticks spent in each green phase (>=1)
- YELLOW_TICKS, 2, ticks spent in each yellow phase (>=1)
- ALLRED_TICKS, 1, ticks of all-red clearance after each yellow (>=1)
- WALK_TICKS, 3, ticks of pedestrian walk phase (>=1)
- CNT_W, 4, phase counter width; must satisfy 2^CNT_W >= max duration

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- tick  in  1  one-cycle timebase pulse; the counter advances only when tick=1
- ped_req  in  1  pedestrian button, level or pulse; sampled every clock
- ns_g, ns_y, ns_r  out  1 each  north-south lamps, exactly one high
- ew_g, ew_y, ew_r  out  1 each  east-west lamps, exactly one high
- walk  out  1  pedestrian walk lamp
- ped_wait  out  1  request latched and not yet served

Behaviour:
- Reset (clk edge with rst=1):
  - state=NS_G, cnt=0, next_dir=EW, ped_pending=0.
  - Outputs: ns_g=1, ew_r=1, all other lamps 0, walk=0, ped_wait=0.
  - rst overrides tick and ped_req, including reset mid-phase or mid-walk.
- States: NS_G, NS_Y, AR (all red), EW_G, EW_Y, WALK.
- Moore outputs decoded from the state register only:
  - NS_G: ns_g=1, ew_r=1.
  - NS_Y: ns_y=1, ew_r=1.
  - AR and WALK: ns_r=1, ew_r=1.
  - EW_G: ew_g=1, ns_r=1.
  - EW_Y: ew_y=1, ns_r=1.
  - walk=1 only in WALK.
- Phase timing:
  - On a clock edge with tick=1: if cnt == DUR(state)-1, take the transition and set cnt=0; else cnt=cnt+1.
  - With tick=0, cnt and state hold.
  - Each state therefore lasts exactly DUR ticks. The first phase after reset is a full GREEN_TICKS.
- Transitions:
  - NS_G -> NS_Y; NS_Y -> AR with next_dir=EW.
  - EW_G -> EW_Y; EW_Y -> AR with next_dir=NS.
  - AR: if ped_pending=1 -> WALK; else -> next_dir green (NS_G or EW_G).
  - WALK -> next_dir green. The walk phase does not change direction order.
- Pedestrian latch:
  - ped_pending <= (ped_pending | ped_req) & ~(state==WALK) & ~(AR exit edge to WALK).
  - A request arriving in the same cycle that WALK is entered, or during WALK, is dropped.
  - A request arriving on the AR exit edge that goes to a green is latched and served at the next AR.
  - ped_wait = ped_pending.
- Safety invariant: never are both ns_g|ns_y and ew_g|ew_y high; the bench asserts this every cycle.
- Nominal cycle with defaults, no pedestrian: 2*(5+2+1)=16 ticks. WALK adds 3 ticks per service.
- tick held high continuously is legal: phases last DUR clocks.

Test Plan:
- Reset 3 cycles, then tick every 6 clocks, ped_req=0:
  - ns_g=1 for 5 ticks, ns_y for 2, all red for 1, ew_g for 5, ew_y for 2, all red for 1, then ns_g again.
  - walk stays 0 throughout; the safety assertion never fires.
- ped_req 1-cycle pulse during NS_G tick 2:
  - ped_wait=1 on the next clock.
  - After NS_Y and AR (1 tick), WALK with walk=1, ns_r=ew_r=1 for 3 ticks; ped_wait=0 from WALK entry.
  - Then ew_g=1.
- ped_req held high through an entire WALK:
  - No second WALK at the following AR unless ped_req is still high after WALK exits.
  - With ped_req held until WALK ends and released there, ped_wait=0 and the next AR goes straight to green.
- rst asserted for 1 cycle during WALK tick 2 with ped_pending later re-requested:
  - Next clock: ns_g=1, ew_r=1, walk=0, ped_wait=0, cnt=0.
  - A full 5-tick NS_G follows.
- tick=1 every clock, defaults: NS_G lasts exactly 5 clocks, NS_Y 2, AR 1; the full cycle is 16 clocks.
- Override GREEN_TICKS=1, YELLOW_TICKS=1, ALLRED_TICKS=2, CNT_W=2, tick every clock:
  - State sequence NS_G(1), NS_Y(1), AR(2), EW_G(1), EW_Y(1), AR(2), repeating every 8 clocks.
